// File: rtl/puf_key_pkg.sv
// Shared types and sizing helpers for the PUF key controller.
// The default sizing constants match the controller's default parameters.
package puf_key_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StSettle,
        StSample,
        StDone,
        StStream
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int unsigned nb_of(input int unsigned n_puf);
        return (n_puf + 7) / 8;
    endfunction

    function automatic int unsigned acc_w_of(input int unsigned n_eval);
        return clog2(n_eval + 1);
    endfunction

    localparam int unsigned N_PUF_DEF  = 16;
    localparam int unsigned N_EVAL_DEF = 5;
    localparam int unsigned NB         = nb_of(N_PUF_DEF);
    localparam int unsigned ACC_W      = acc_w_of(N_EVAL_DEF);

    // Wide enough for any legal CHAL_W; users slice the low bits.
    localparam logic [255:0] CHAL_RST    = '1;
    localparam logic         EXCITE_IDLE = 1'b1;

endpackage

// File: rtl/puf_vote_acc.sv
// Per-bit vote accumulators; key and unanimity flags are derived
// combinationally from the running counts.
module puf_vote_acc
    import puf_key_pkg::*;
#(
    parameter int unsigned N_PUF  = 16,
    parameter int unsigned N_EVAL = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             add,
    input  logic [N_PUF-1:0] resp,
    output logic [N_PUF-1:0] key,
    output logic [N_PUF-1:0] unstable
);

    localparam int unsigned VOTE_W = acc_w_of(N_EVAL);
    localparam logic [VOTE_W-1:0] HALF = VOTE_W'(N_EVAL / 2);
    localparam logic [VOTE_W-1:0] FULL = VOTE_W'(N_EVAL);

    logic [VOTE_W-1:0] acc_q [N_PUF];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_PUF; i++) begin
                acc_q[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < N_PUF; i++) begin
                acc_q[i] <= '0;
            end
        end else if (add) begin
            for (int i = 0; i < N_PUF; i++) begin
                acc_q[i] <= acc_q[i] + VOTE_W'(resp[i]);
            end
        end
    end

    always_comb begin
        key      = '0;
        unstable = '0;
        for (int i = 0; i < N_PUF; i++) begin
            key[i]      = acc_q[i] > HALF;
            unstable[i] = (acc_q[i] != '0) && (acc_q[i] != FULL);
        end
    end

endmodule

// File: rtl/puf_key_ctrl.sv
// Arbiter-PUF key controller: excite sequencing, N_EVAL-fold majority vote,
// and byte-serial key streaming over a valid/ready handshake.
module puf_key_ctrl
    import puf_key_pkg::*;
#(
    parameter int unsigned N_PUF          = 16,
    parameter int unsigned CHAL_W         = 16,
    parameter int unsigned N_EVAL         = 5,
    parameter int unsigned EXCITE_LOW_CYC = 19,
    parameter int unsigned SETTLE_CYC     = 30
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic [CHAL_W-1:0] Chal_in,
    output logic [CHAL_W-1:0] Challenge,
    output logic              ExciteL,
    output logic              ExciteR,
    input  logic [N_PUF-1:0]  R_in,
    output logic              Busy,
    output logic [N_PUF-1:0]  Key_out,
    output logic [N_PUF-1:0]  Unstable,
    output logic              Key_valid,
    output logic [7:0]        Byte_out,
    output logic              Byte_valid,
    input  logic              Byte_ready
);

    localparam int unsigned NUM_BYTES = nb_of(N_PUF);
    localparam int unsigned CYC_MAX   =
        (EXCITE_LOW_CYC > SETTLE_CYC) ? EXCITE_LOW_CYC : SETTLE_CYC;
    localparam int unsigned CNT_W     = clog2(CYC_MAX + 1);
    localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? clog2(NUM_BYTES) : 1;

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(EXCITE_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] SET_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [3:0]       EVAL_LAST = 4'(N_EVAL - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_BYTES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [3:0]        eval_q, eval_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  idx_nxt;
    logic [CHAL_W-1:0] chal_q, chal_d;
    logic              excite_q, excite_d;
    logic [N_PUF-1:0]  key_q, key_d;
    logic [N_PUF-1:0]  unst_q, unst_d;
    logic              kv_q, kv_d;
    logic [7:0]        byte_q, byte_d;
    logic              bv_q, bv_d;

    logic              acc_clr, acc_add;
    logic [N_PUF-1:0]  vote_key, vote_unst;
    logic [NUM_BYTES*8-1:0] pad_key;
    logic [7:0]        first_byte;

    puf_vote_acc #(
        .N_PUF  (N_PUF),
        .N_EVAL (N_EVAL)
    ) u_vote (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .clr      (acc_clr),
        .add      (acc_add),
        .resp     (R_in),
        .key      (vote_key),
        .unstable (vote_unst)
    );

    // Bits above N_PUF stream out as zero padding.
    always_comb begin
        pad_key = '0;
        pad_key[N_PUF-1:0] = key_q;
        first_byte = '0;
        for (int i = 0; i < 8; i++) begin
            if (i < N_PUF) begin
                first_byte[i] = vote_key[i];
            end
        end
    end

    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        eval_d   = eval_q;
        idx_d    = idx_q;
        chal_d   = chal_q;
        excite_d = excite_q;
        key_d    = key_q;
        unst_d   = unst_q;
        kv_d     = kv_q;
        byte_d   = byte_q;
        bv_d     = bv_q;
        acc_clr  = 1'b0;
        acc_add  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    chal_d   = Chal_in;
                    excite_d = 1'b0;
                    acc_clr  = 1'b1;
                    eval_d   = '0;
                    cyc_d    = '0;
                    kv_d     = 1'b0;
                    state_d  = StPre;
                end
            end
            StPre: begin
                if (cyc_q == PRE_LAST) begin
                    cyc_d    = '0;
                    excite_d = 1'b1;
                    state_d  = StSettle;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StSettle: begin
                if (cyc_q == SET_LAST) begin
                    cyc_d   = '0;
                    state_d = StSample;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            StSample: begin
                acc_add = 1'b1;
                eval_d  = eval_q + 1'b1;
                if (eval_q == EVAL_LAST) begin
                    state_d = StDone;
                end else begin
                    excite_d = 1'b0;
                    state_d  = StPre;
                end
            end
            StDone: begin
                // Accumulators are final here; capture key and preload byte 0.
                key_d   = vote_key;
                unst_d  = vote_unst;
                kv_d    = 1'b1;
                byte_d  = first_byte;
                bv_d    = 1'b1;
                idx_d   = '0;
                state_d = StStream;
            end
            StStream: begin
                if (Byte_ready) begin
                    if (idx_q == IDX_LAST) begin
                        bv_d    = 1'b0;
                        state_d = StIdle;
                    end else begin
                        idx_d  = idx_nxt;
                        byte_d = pad_key[int'(idx_nxt) * 8 +: 8];
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q  <= StIdle;
            cyc_q    <= '0;
            eval_q   <= '0;
            idx_q    <= '0;
            chal_q   <= CHAL_RST[CHAL_W-1:0];
            excite_q <= EXCITE_IDLE;
            key_q    <= '0;
            unst_q   <= '0;
            kv_q     <= 1'b0;
            byte_q   <= '0;
            bv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            eval_q   <= eval_d;
            idx_q    <= idx_d;
            chal_q   <= chal_d;
            excite_q <= excite_d;
            key_q    <= key_d;
            unst_q   <= unst_d;
            kv_q     <= kv_d;
            byte_q   <= byte_d;
            bv_q     <= bv_d;
        end
    end

    assign Challenge  = chal_q;
    assign ExciteL    = excite_q;
    assign ExciteR    = excite_q;
    assign Busy       = (state_q != StIdle);
    assign Key_out    = key_q;
    assign Unstable   = unst_q;
    assign Key_valid  = kv_q;
    assign Byte_out   = byte_q;
    assign Byte_valid = bv_q;

endmodule

// File: tb/tb_puf_key_ctrl.sv
// Randomized bench for puf_key_ctrl: default instance plus a 12-bit,
// single-evaluation instance, both checked against a counting vote model.
module tb_puf_key_ctrl;

    localparam int unsigned N_EVAL = 5;
    localparam int unsigned LOW    = 19;
    localparam int unsigned SETL   = 30;
    localparam int unsigned PER    = LOW + SETL + 1;

    logic        Clk = 1'b0;
    logic        Rst_n, Start, Byte_ready;
    logic [15:0] Chal_in, R_in, Challenge, Key_out, Unstable;
    logic        ExciteL, ExciteR, Busy, Key_valid, Byte_valid;
    logic [7:0]  Byte_out;

    logic        Start2, Ready2;
    logic [15:0] Chal2, Challenge2;
    logic [11:0] R2, Key2, Unst2;
    logic        ExL2, ExR2, Busy2, Kv2, Bv2;
    logic [7:0]  Byte2;

    logic [15:0] resp_tab [N_EVAL];
    logic [15:0] last_key, last_chal;

    int n_vec = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    puf_key_ctrl dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Chal_in(Chal_in),
        .Challenge(Challenge), .ExciteL(ExciteL), .ExciteR(ExciteR), .R_in(R_in),
        .Busy(Busy), .Key_out(Key_out), .Unstable(Unstable), .Key_valid(Key_valid),
        .Byte_out(Byte_out), .Byte_valid(Byte_valid), .Byte_ready(Byte_ready)
    );

    puf_key_ctrl #(.N_PUF(12), .N_EVAL(1)) dut2 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start2), .Chal_in(Chal2),
        .Challenge(Challenge2), .ExciteL(ExL2), .ExciteR(ExR2), .R_in(R2),
        .Busy(Busy2), .Key_out(Key2), .Unstable(Unst2), .Key_valid(Kv2),
        .Byte_out(Byte2), .Byte_valid(Bv2), .Byte_ready(Ready2)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Majority by counting ones per bit across the stored evaluations.
    task automatic vote_model(output logic [15:0] key, output logic [15:0] unst);
        for (int i = 0; i < 16; i++) begin
            int ones;
            ones = 0;
            for (int e = 0; e < N_EVAL; e++) ones += int'(resp_tab[e][i]);
            key[i]  = (2 * ones > N_EVAL);
            unst[i] = (ones > 0) && (ones < N_EVAL);
        end
    endtask

    task automatic gen_key(input logic [15:0] chal, input bit poke_pre, input int abort_eval);
        logic [15:0] mk, mu;
        bit ex;
        vote_model(mk, mu);
        Start = 1'b1;
        Chal_in = chal;
        tick();
        Start = 1'b0;
        Chal_in = 16'($urandom);
        check_eq("accept_chal", Challenge, chal);
        check_eq("accept_busy", Busy, 1);
        check_eq("accept_kv", Key_valid, 0);
        for (int e = 0; e < N_EVAL; e++) begin
            R_in = resp_tab[e];
            for (int t = 0; t < PER; t++) begin
                ex = (t >= LOW);
                if (t == 0 || t == LOW - 1 || t == LOW || t == PER - 1) begin
                    check_eq("excite_l", ExciteL, ex);
                    check_eq("excite_r", ExciteR, ex);
                end
                if (e == abort_eval && t == LOW + 5) begin
                    Rst_n = 1'b0;
                    tick();
                    Rst_n = 1'b1;
                    check_eq("abort_excite_l", ExciteL, 1);
                    check_eq("abort_excite_r", ExciteR, 1);
                    check_eq("abort_chal", Challenge, 16'hFFFF);
                    check_eq("abort_kv", Key_valid, 0);
                    check_eq("abort_busy", Busy, 0);
                    check_eq("abort_key", Key_out, 0);
                    check_eq("abort_bv", Byte_valid, 0);
                    return;
                end
                Start = poke_pre && (e == 1) && (t == 3);
                tick();
                Start = 1'b0;
            end
        end
        check_eq("kv_early", Key_valid, 0);
        check_eq("busy_done", Busy, 1);
        tick();
        check_eq("kv_rise", Key_valid, 1);
        check_eq("key", Key_out, mk);
        check_eq("unstable", Unstable, mu);
        check_eq("chal_hold", Challenge, chal);
        last_key  = mk;
        last_chal = chal;
    endtask

    task automatic stream(input logic [15:0] key, input int mode, input bit poke);
        bit rdy;
        bit took;
        int waits;
        for (int j = 0; j < 2; j++) begin
            took  = 1'b0;
            waits = 0;
            while (!took && waits <= 40) begin
                check_eq("byte_valid", Byte_valid, 1);
                check_eq("byte_out", Byte_out, key[8*j +: 8]);
                case (mode)
                    1:       rdy = 1'($urandom_range(0, 1));
                    2:       rdy = (j != 0) || (waits >= 7);
                    default: rdy = 1'b1;
                endcase
                Byte_ready = rdy;
                Start = poke && (j == 0) && (waits == 0);
                Chal_in = 16'($urandom);
                tick();
                Start = 1'b0;
                if (rdy) took = 1'b1;
                else waits++;
            end
            if (!took) check_eq("stream_bound", waits, 0);
        end
        Byte_ready = 1'b1;
        check_eq("stream_end_bv", Byte_valid, 0);
        check_eq("stream_end_busy", Busy, 0);
        if (poke) begin
            tick();
            tick();
            check_eq("poke_idle", Busy, 0);
        end
        check_eq("key_hold", Key_out, key);
        check_eq("kv_hold", Key_valid, 1);
        check_eq("chal_keep", Challenge, last_chal);
    endtask

    task automatic gen2(input logic [11:0] resp);
        Start2 = 1'b1;
        Chal2 = 16'($urandom);
        tick();
        Start2 = 1'b0;
        R2 = resp;
        repeat (PER) tick();
        check_eq("n1_kv_early", Kv2, 0);
        tick();
        // A single evaluation is its own majority and is always unanimous.
        check_eq("n1_kv", Kv2, 1);
        check_eq("n1_key", Key2, resp);
        check_eq("n1_unst", Unst2, 0);
        check_eq("n1_byte0", Byte2, resp[7:0]);
        check_eq("n1_bv0", Bv2, 1);
        tick();
        check_eq("n1_byte1", Byte2, {4'h0, resp[11:8]});
        check_eq("n1_bv1", Bv2, 1);
        tick();
        check_eq("n1_bv_end", Bv2, 0);
        check_eq("n1_busy_end", Busy2, 0);
    endtask

    initial begin
        logic [15:0] base;
        Rst_n = 1'b0; Start = 1'b0; Chal_in = '0; R_in = '0; Byte_ready = 1'b1;
        Start2 = 1'b0; Chal2 = '0; R2 = '0; Ready2 = 1'b1;
        last_key = '0; last_chal = '0;
        tick();
        tick();
        check_eq("rst_chal", Challenge, 16'hFFFF);
        check_eq("rst_excite_l", ExciteL, 1);
        check_eq("rst_excite_r", ExciteR, 1);
        check_eq("rst_key", Key_out, 0);
        check_eq("rst_unst", Unstable, 0);
        check_eq("rst_kv", Key_valid, 0);
        check_eq("rst_byte", Byte_out, 0);
        check_eq("rst_bv", Byte_valid, 0);
        check_eq("rst_busy", Busy, 0);
        check_eq("rst2_chal", Challenge2, 16'hFFFF);
        Rst_n = 1'b1;
        tick();
        check_eq("idle_busy", Busy, 0);

        // Constant response
        for (int e = 0; e < N_EVAL; e++) resp_tab[e] = 16'hA5C3;
        gen_key(16'hAAAA, 1'b0, -1);
        stream(last_key, 0, 1'b0);

        // Split votes on bit 0
        resp_tab[0] = 16'h1; resp_tab[1] = 16'h0; resp_tab[2] = 16'h1;
        resp_tab[3] = 16'h0; resp_tab[4] = 16'h1;
        gen_key(16'h0F0F, 1'b0, -1);
        stream(last_key, 0, 1'b0);
        resp_tab[0] = 16'h0;
        gen_key(16'h3C3C, 1'b0, -1);
        stream(last_key, 0, 1'b0);

        // Backpressure on the first byte
        for (int e = 0; e < N_EVAL; e++) resp_tab[e] = 16'hA5C3;
        gen_key(16'h5555, 1'b0, -1);
        stream(last_key, 2, 1'b0);

        // Reset during the third settle, then a clean run
        gen_key(16'h1234, 1'b0, 2);
        gen_key(16'hBEEF, 1'b0, -1);
        stream(last_key, 0, 1'b0);

        // Start pulses while busy are ignored
        for (int e = 0; e < N_EVAL; e++) resp_tab[e] = 16'($urandom);
        gen_key(16'($urandom), 1'b1, -1);
        stream(last_key, 1, 1'b1);

        // Mostly-stable random responses with sparse flips
        for (int r = 0; r < 6; r++) begin
            base = 16'($urandom);
            for (int e = 0; e < N_EVAL; e++)
                resp_tab[e] = base ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            gen_key(16'($urandom), 1'b0, -1);
            stream(last_key, 1, 1'b0);
        end

        gen2(12'hFFF);
        gen2(12'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/puf_key_ctrl.md
Name: puf_key_ctrl

Overview:
Parametrised controller for an array of N_PUF DAPUF-style arbiter PUF instances. It latches a challenge, then sequences the excite lines through a precharge/launch/settle cycle. It samples the responses N_EVAL times, majority-votes each bit into a key, and flags unstable bits. The key is streamed out byte-serially over a valid/ready handshake, for LED display or a downstream fuzzy extractor.

Parameters:
N_PUF, 16, number of PUF instances (response/key width), 1..256
CHAL_W, 16, challenge width driven to every PUF
N_EVAL, 5, evaluations per key; must be odd, 1..15
EXCITE_LOW_CYC, 19, cycles excite held low (precharge) per evaluation, >=1
SETTLE_CYC, 30, cycles after excite rises before sampling, >=1

Ports:
Clk  in  1  system clock, all logic on rising edge
Rst_n  in  1  synchronous active-low reset
Start  in  1  request key generation; sampled only in IDLE
Chal_in  in  CHAL_W  challenge, latched when Start is accepted
Challenge  out  CHAL_W  registered challenge to all PUFs
ExciteL  out  1  left excite line to all PUFs
ExciteR  out  1  right excite line, always equal to ExciteL
R_in  in  N_PUF  raw PUF responses
Busy  out  1  high in any state other than IDLE
Key_out  out  N_PUF  majority-voted key
Unstable  out  N_PUF  1 = bit did not vote unanimously
Key_valid  out  1  Key_out/Unstable valid
Byte_out  out  8  key byte stream, LSB byte first
Byte_valid  out  1  Byte_out valid
Byte_ready  in  1  consumer accepts byte when Byte_valid&&Byte_ready

Behaviour:
- Reset values (Rst_n=0 at a rising edge):
  - state=IDLE; ExciteL=ExciteR=1; Challenge all ones.
  - Key_out=0, Unstable=0, Key_valid=0, Byte_out=0, Byte_valid=0.
  - All counters and vote accumulators 0.
- Reset mid-operation aborts immediately to these values. No partial key is ever presented.
- States: IDLE, PRE, SETTLE, SAMPLE, DONE, STREAM.
- IDLE:
  - Start=1 at edge k: Challenge<=Chal_in, excite<=0, accumulators cleared, eval_cnt<=0, Key_valid<=0, go to PRE.
  - Start=0: remain in IDLE; outputs hold.
- PRE: excite=0 for EXCITE_LOW_CYC cycles, then excite<=1, go to SETTLE.
- SETTLE: excite=1 for SETTLE_CYC cycles, then go to SAMPLE.
- SAMPLE (1 cycle):
  - acc[i] += R_in[i] for all bits; eval_cnt++.
  - If eval_cnt < N_EVAL-1: excite<=0, go to PRE. Otherwise go to DONE.
- DONE (1 cycle):
  - Key_out[i] = (acc[i] > N_EVAL/2).
  - Unstable[i] = (acc[i] != 0 && acc[i] != N_EVAL).
  - Key_valid<=1; go to STREAM.
  - Key_valid rises at edge k + N_EVAL*(EXCITE_LOW_CYC+SETTLE_CYC+1) + 1 (251 with defaults).
- Accumulator width: clog2(N_EVAL+1) per bit; never overflows.
- STREAM:
  - NB = ceil(N_PUF/8) bytes, byte j = Key_out[8j+7:8j].
  - Bits at or above N_PUF are zero-padded.
  - Byte_valid rises the cycle after DONE.
  - Byte_out holds stable while Byte_valid && !Byte_ready.
  - On handshake, the next byte appears the following cycle with no bubble.
  - After the last handshake: Byte_valid<=0, go to IDLE.
- Key_out, Unstable and Key_valid hold until the next accepted Start.
- Start in any non-IDLE state is ignored (no queueing).
- Challenge is stable from the accepting edge until the next accepted Start.
- ExciteL and ExciteR are never different and change only on Clk edges.

Decomposition:
- Package puf_key_pkg:
  - state enum.
  - function clog2.
  - localparams: NB = ceil(N_PUF/8), ACC_W = clog2(N_EVAL+1).
  - reset constants: CHAL_RST = all ones, EXCITE_IDLE = 1.
- Sub-module puf_vote_acc: N_PUF per-bit accumulators with clear/add controls. It produces Key and Unstable combinationally from the accumulators. The controller registers both in DONE.

Test Plan:
1. Defaults; R_in model constant 16'hA5C3; Start with Chal_in=16'hAAAA, Byte_ready=1 → Challenge=AAAA, excite low 19 cycles per eval × 5 evals, Key_valid at edge k+251, Key_out=A5C3, Unstable=0, bytes C3 then A5.
2. R_in bit0 sequence 1,0,1,0,1 across evals (others 0) → Key_out=0001, Unstable=0001; with sequence 0,0,1,0,1 → Key_out=0000, Unstable=0001.
3. Backpressure: Byte_ready low 7 cycles after Byte_valid rises → Byte_out=C3 held 7 cycles; A5 appears one cycle after the handshake; Busy drops after the second handshake.
4. Rst_n low during the third SETTLE → next edge: ExciteL/R=1, Challenge=FFFF, Key_valid=0, Busy=0; a new Start completes normally.
5. Start pulsed during PRE and during STREAM → ignored; exactly one key and NB bytes are produced.
6. N_PUF=12, N_EVAL=1, R_in=12'hFFF → Key_out=FFF, bytes FF then 0F, Key_valid at edge k+51.
